// File: rtl/rv_lsu_pkg.sv
// Shared types and lane helpers for the RV32I load/store unit.
//   size_e  : access size as carried on req_size_i
//   state_e : LSU control state
//   lsu_extract : pick and extend a byte/half/word lane out of a memory word
//   lsu_merge   : replace a byte/half lane of a memory word with store data
package rv_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    function automatic logic [31:0] lsu_extract(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input size_e       size,
                                                input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = 8'h00;
        h   = 16'h0000;
        res = 32'h0;
        case (offset)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            SZ_WORD: res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lsu_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  offset,
                                              input size_e       size);
        logic [31:0] res;
        res = old_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    default: res[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) res[31:16] = wdata[15:0];
                else           res[15:0]  = wdata[15:0];
            end
            SZ_WORD: res = wdata;
            default: res = old_word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// Request/response handshake bundle between the execute stage and the LSU.
// Handshake: a request transfers on a rising clk edge where req_valid_i and
// req_ready_o are both 1; a response transfers on an edge where rsp_valid_o and
// rsp_ready_i are both 1. A raised valid and its payload stay stable until the
// transfer edge.
//   slave  : the LSU side
//   master : the execute-stage side (or a testbench driver)
interface rv_lsu_if;
    import rv_lsu_pkg::*;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_wr_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport slave (
        input  req_valid_i, req_wr_i, req_size_i, req_unsigned_i, req_addr_i,
               req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_size_i, req_unsigned_i, req_addr_i,
               req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

endinterface

// File: rtl/rv_lsu_align.sv
// Combinational lane logic for the LSU.
//   word_i  : memory word being loaded
//   old_i   : memory word read back for a sub-word store
//   wdata_i : right-aligned store data
//   offset_i, size_i, uns_i : captured addr[1:0], access size, zero-extend flag
//   load_o  : extended load value
//   merge_o : full word to write back
module rv_lsu_align
    import rv_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  size_e       size_i,
    input  logic        uns_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    always_comb begin
        load_o  = lsu_extract(word_i, offset_i, size_i, uns_i);
        merge_o = lsu_merge(old_i, wdata_i, offset_i, size_i);
    end

endmodule

// File: rtl/rv_lsu.sv
// RV32I load/store unit in front of a word-indexed, whole-word-write data memory.
// Sub-word stores are done as read-modify-write since the memory has no byte enables.
//   clk, resetn      : core clock, asynchronous active-low reset
//   bus              : request/response handshake (rv_lsu_if.slave)
//   dmem_addr_o      : word index into the data memory
//   dmem_wr_o        : write strobe; memory writes on the rising edge
//   dmem_wr_data_o   : full word to write
//   dmem_data_i      : combinational read data for dmem_addr_o
//   dbg_state_o      : current control state
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    rv_lsu_if.slave     bus,
    output logic [31:0] dmem_addr_o,
    output logic        dmem_wr_o,
    output logic [31:0] dmem_wr_data_o,
    input  logic [31:0] dmem_data_i,
    output state_e      dbg_state_o
);

    localparam logic [31:0] DMEM_WORDS_W = 32'(DMEM_WORDS);

    state_e      state_q, state_d;
    size_e       size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        uns_q;
    logic [31:0] old_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept = bus.req_valid_i && (state_q == ST_IDLE);

    // Any of these faults skips memory entirely and answers with err=1.
    always_comb begin
        req_err = 1'b0;
        if (bus.req_size_i == 2'b11)                                req_err = 1'b1;
        if ((bus.req_size_i == 2'b01) && bus.req_addr_i[0])         req_err = 1'b1;
        if ((bus.req_size_i == 2'b10) && (bus.req_addr_i[1:0] != 2'b00)) req_err = 1'b1;
        if ({2'b00, bus.req_addr_i[31:2]} >= DMEM_WORDS_W)          req_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    if (req_err)                       state_d = ST_RESP;
                    else if (!bus.req_wr_i)            state_d = ST_LOAD;
                    else if (bus.req_size_i == 2'b10)  state_d = ST_WRITE;
                    else                               state_d = ST_READ;
                end
            end
            ST_LOAD:  state_d = ST_RESP;
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            size_q  <= SZ_BYTE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            uns_q   <= 1'b0;
            old_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                size_q  <= size_e'(bus.req_size_i);
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
                uns_q   <= bus.req_unsigned_i;
                err_q   <= req_err;
                // Stores and faults report zero; loads overwrite this in LOAD.
                rdata_q <= 32'h0;
            end
            if (state_q == ST_LOAD) rdata_q <= load_data;
            if (state_q == ST_READ) old_q   <= dmem_data_i;
        end
    end

    rv_lsu_align u_align (
        .word_i   (dmem_data_i),
        .old_i    (old_q),
        .wdata_i  (wdata_q),
        .offset_i (addr_q[1:0]),
        .size_i   (size_q),
        .uns_i    (uns_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    // Memory-side outputs depend only on captured registers and state, so a
    // changing request bus can never disturb an access in flight.
    assign dmem_addr_o    = {2'b00, addr_q[31:2]};
    assign dmem_wr_o      = (state_q == ST_WRITE);
    assign dmem_wr_data_o = merge_data;

    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = (state_q == ST_RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rv_lsu.sv
// Bench for rv_lsu: directed cases plus randomized traffic, checked against a
// word-array reference model of the data memory and the LSU's load/store rules.
module tb_rv_lsu;
    import rv_lsu_pkg::*;

    logic        clk;
    logic        resetn;
    logic [31:0] dmem_addr_o;
    logic        dmem_wr_o;
    logic [31:0] dmem_wr_data_o;
    logic [31:0] dmem_data_i;
    state_e      dbg_state;

    rv_lsu_if bus ();

    rv_lsu #(.DMEM_WORDS(1024)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .bus            (bus),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wr_o      (dmem_wr_o),
        .dmem_wr_data_o (dmem_wr_data_o),
        .dmem_data_i    (dmem_data_i),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data memory stand-in ----------------
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          wr_count = 0;

    assign dmem_data_i = (dmem_addr_o < 32'd1024) ? mem[dmem_addr_o[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (dmem_wr_o) begin
            mem[dmem_addr_o[9:0]] <= dmem_wr_data_o;
            wr_count <= wr_count + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: decides fault/latency/result from the access rules and
    // updates ref_mem the way the store should leave memory.
    task automatic model(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output bit err, output logic [31:0] rd,
                         output int lat, output int writes);
        logic [31:0] idx, off, w, v, mask, lanebits;
        idx = a >> 2;
        off = a % 4;
        err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
              (sz == 2'd2 && off != 0) || (idx >= 1024);
        rd = 32'h0;
        writes = 0;
        if (err) begin
            lat = 1;
            return;
        end
        w = ref_mem[idx[9:0]];
        if (!wr) begin
            lat = 2;
            if (sz == 2'd2) rd = w;
            else if (sz == 2'd0) begin
                v = (w >> (8 * off)) & 32'hFF;
                if (!uns && v >= 128) v = v - 32'd256;
                rd = v;
            end else begin
                v = (w >> (8 * off)) & 32'hFFFF;
                if (!uns && v >= 32768) v = v - 32'd65536;
                rd = v;
            end
        end else begin
            writes = 1;
            if (sz == 2'd2) begin
                lat = 2;
                ref_mem[idx[9:0]] = wd;
            end else begin
                lat = 3;
                lanebits = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
                mask = lanebits << (8 * off);
                ref_mem[idx[9:0]] = (w & ~mask) | ((wd & lanebits) << (8 * off));
            end
        end
    endtask

    // ---------------- driver ----------------
    // Issues one request, checks accept, latency, response, stall behaviour,
    // write-pulse count and the touched memory word.
    task automatic run_req(input string tag, input bit wr, input logic [1:0] sz,
                           input bit uns, input logic [31:0] a, input logic [31:0] wd,
                           input int stall);
        bit          e_err;
        logic [31:0] e_rd;
        int          e_lat, e_wr, wr0, lat, budget;
        bit          acc, seen, rdy;
        logic [31:0] idx;
        model(wr, sz, uns, a, wd, e_err, e_rd, e_lat, e_wr);
        idx = a >> 2;
        @(negedge clk);
        wr0 = wr_count;
        bus.req_valid_i    = 1'b1;
        bus.req_wr_i       = wr;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = a;
        bus.req_wdata_i    = wd;
        acc = 0;
        budget = 0;
        while (!acc && budget < 20) begin
            rdy = bus.req_ready_o;
            @(posedge clk);
            if (rdy) acc = 1;
            else @(negedge clk);
            budget++;
        end
        chk({tag, " accept"}, 32'(acc), 32'd1);
        lat = 0;
        seen = 0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus.req_valid_i = 1'b0;
                bus.req_addr_i  = $urandom;
                bus.req_wdata_i = $urandom;
            end
            if (bus.rsp_valid_o) seen = 1;
        end
        chk({tag, " latency"}, 32'(lat), 32'(e_lat));
        chk({tag, " err"}, 32'(bus.rsp_err_o), 32'(e_err));
        chk({tag, " rdata"}, bus.rsp_rdata_o, e_rd);
        // Stall the response while offering a competing store to word 0.
        for (int i = 0; i < stall; i++) begin
            bus.req_valid_i = 1'b1;
            bus.req_wr_i    = 1'b1;
            bus.req_size_i  = 2'd2;
            bus.req_addr_i  = 32'h0;
            bus.req_wdata_i = $urandom;
            @(negedge clk);
            chk({tag, " hold valid"}, 32'(bus.rsp_valid_o), 32'd1);
            chk({tag, " hold rdata"}, bus.rsp_rdata_o, e_rd);
            chk({tag, " hold ready"}, 32'(bus.req_ready_o), 32'd0);
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        chk({tag, " rsp done"}, 32'(bus.rsp_valid_o), 32'd0);
        chk({tag, " writes"}, 32'(wr_count - wr0), 32'(e_wr));
        if (idx < 1024) chk({tag, " mem"}, mem[idx[9:0]], ref_mem[idx[9:0]]);
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        mem[idx]     = val;
        ref_mem[idx] = val;
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] old8;
    int          wr_before;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        bus.req_valid_i    = 1'b0;
        bus.req_wr_i       = 1'b0;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'h0;
        bus.req_wdata_i    = 32'h0;
        bus.rsp_ready_i    = 1'b0;
        resetn = 1'b0;
        #12;
        chk("reset ready",    32'(bus.req_ready_o), 32'd1);
        chk("reset rvalid",   32'(bus.rsp_valid_o), 32'd0);
        chk("reset rdata",    bus.rsp_rdata_o,      32'h0);
        chk("reset err",      32'(bus.rsp_err_o),   32'd0);
        chk("reset dwr",      32'(dmem_wr_o),       32'd0);
        chk("reset daddr",    dmem_addr_o,          32'h0);
        chk("reset dwdata",   dmem_wr_data_o,       32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // 1: word store then load
        run_req("t1 sw", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
        chk("t1 mem4", mem[4], 32'hDEADBEEF);
        run_req("t1 lw", 0, 2'd2, 0, 32'h10, 32'h0, 0);

        // 2: byte store into lane 3, signed/unsigned byte loads
        preload(4, 32'h11223344);
        run_req("t2 sb", 1, 2'd0, 0, 32'h13, 32'h000000AB, 0);
        chk("t2 mem4", mem[4], 32'hAB223344);
        run_req("t2 lb", 0, 2'd0, 0, 32'h13, 32'h0, 0);
        run_req("t2 lbu", 0, 2'd0, 1, 32'h13, 32'h0, 0);

        // 3: halfword loads from both halves, upper-half store
        preload(5, 32'h80007FFF);
        run_req("t3 lh hi", 0, 2'd1, 0, 32'h16, 32'h0, 0);
        run_req("t3 lh lo", 0, 2'd1, 0, 32'h14, 32'h0, 0);
        run_req("t3 sh", 1, 2'd1, 0, 32'h16, 32'h00001234, 0);
        chk("t3 mem5", mem[5], 32'h12347FFF);

        // 4: faults and the top-of-memory boundary
        run_req("t4 lw mis", 0, 2'd2, 0, 32'h11, 32'h0, 0);
        run_req("t4 sh mis", 1, 2'd1, 0, 32'h15, 32'h5555, 0);
        run_req("t4 size3", 0, 2'd3, 0, 32'h10, 32'h0, 0);
        run_req("t4 sw oor", 1, 2'd2, 0, 32'h1000, 32'h77777777, 0);
        run_req("t4 sw top", 1, 2'd2, 0, 32'hFFC, 32'hCAFEF00D, 0);
        run_req("t4 lw top", 0, 2'd2, 0, 32'hFFC, 32'h0, 0);

        // 5: response held off for five cycles
        run_req("t5 stall", 0, 2'd2, 0, 32'h10, 32'h0, 5);

        // 6: reset while an SB is in READ
        old8 = ref_mem[8];
        @(negedge clk);
        wr_before = wr_count;
        bus.req_valid_i    = 1'b1;
        bus.req_wr_i       = 1'b1;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'h20;
        bus.req_wdata_i    = 32'h5A;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        chk("t6 in read", 32'(dbg_state), 32'(ST_READ));
        resetn = 1'b0;
        #1;
        chk("t6 ready",  32'(bus.req_ready_o), 32'd1);
        chk("t6 rvalid", 32'(bus.rsp_valid_o), 32'd0);
        chk("t6 dwr",    32'(dmem_wr_o),       32'd0);
        chk("t6 daddr",  dmem_addr_o,          32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("t6 mem8",   mem[8], old8);
        chk("t6 writes", 32'(wr_count - wr_before), 32'd0);
        resetn = 1'b1;
        run_req("t6 after", 1, 2'd0, 0, 32'h20, 32'h5A, 0);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            bit          r_wr, r_uns;
            logic [1:0]  r_sz;
            logic [31:0] r_a;
            int          pick;
            r_wr  = 1'($urandom_range(0, 1));
            r_uns = 1'($urandom_range(0, 1));
            r_sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            pick  = $urandom_range(0, 9);
            if (pick == 0)      r_a = $urandom;
            else if (pick == 1) r_a = 32'h1000 + 32'($urandom_range(0, 15));
            else                r_a = 32'($urandom_range(0, 63));
            run_req("rand", r_wr, r_sz, r_uns, r_a, $urandom, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
